icache_refill_responder: RTL

- Memory-side end of the icache miss/refill interface. Accepts block-fill requests from the IFU and returns one ICACHE_DATA_BLOCK_SIZE block on dram_response/dram_response_valid after a fixed latency.
- Holds a backing store that a bench or boot loader preloads one 32-bit word at a time.
- Sits between the IFU icache and the DRAM model. It replaces hand-driven dram_response stimulus in IFU benches.

---
 rtl/icache_refill_responder_pkg.sv | 32 +++
 rtl/refill_req_fifo.sv | 66 ++++++
 rtl/icache_refill_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_responder_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_responder_pkg
// Shared types and constants for the icache refill responder.
//   ICACHE_BLOCK_WORDS : 32-bit words per refill block
//   WORD_W             : backing-store word width
//   CNT_W              : latency counter width (LATENCY up to 15, +3 jitter)
//   refill_state_t     : refill engine states
// Reuses `ADDR_WIDTH and `ICACHE_DATA_BLOCK_SIZE from the global defines. If
// they are not already defined, local fallbacks are used.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif

package icache_refill_responder_pkg;

  localparam int ICACHE_BLOCK_WORDS = 2;
  localparam int WORD_W             = 32;
  localparam int PKG_ADDR_WIDTH     = `ADDR_WIDTH;
  localparam int PKG_BLOCK_W        = `ICACHE_DATA_BLOCK_SIZE;
  localparam int CNT_W              = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } refill_state_t;

endpackage

// File: rtl/refill_req_fifo.sv
// -----------------------------------------------------------------------------
// refill_req_fifo
// DEPTH-entry FIFO of pending refill block addresses.
// Ports:
//   clk, rst_aH      : clock, asynchronous active-high reset
//   clear            : synchronous flush; empties the FIFO and blocks any
//                      push/pop on the same edge
//   push, push_data  : enqueue one address (ignored when full)
//   pop              : dequeue the head (ignored when empty)
//   head             : current head entry, valid when !empty
//   empty, full      : occupancy flags
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module refill_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_aH,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] slots [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be distinguished.
  logic [PW:0]  wr_q;
  logic [PW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // NOTE: storage arrays get no reset; only the pointers define validity, and
  // leaving the array unreset lets it map onto plain RAM/flops without a reset net.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_q[PW-1:0]] <= push_data;
  end

  // NOTE: clocked state is always written with <=, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  assign head  = slots[rd_q[PW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/icache_refill_responder.sv
// -----------------------------------------------------------------------------
// icache_refill_responder
// Memory-side end of the icache miss/refill interface. Queues block-fill
// requests from the IFU and returns each block on dram_response after a fixed
// latency from a word-loadable backing store.
// Ports:
//   clk                 : clock
//   rst_aH              : asynchronous active-high reset
//   req_valid/req_addr  : miss request (byte address, bits [2:0] ignored)
//   req_ready           : request can be accepted this cycle
//   flush               : drop all queued and in-flight work
//   load_we/addr/data   : backdoor 32-bit word write (bits [1:0] ignored)
//   dram_response       : {word@base+4, word@base}
//   dram_response_valid : one-cycle response strobe
//   dram_response_addr  : block base address of the response
//   busy                : queue non-empty or engine not idle
// Optional: define ICACHE_REFILL_JITTER_EN to add 0..3 cycles of LFSR-driven
// latency jitter per request.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ICACHE_DATA_BLOCK_SIZE
`define ICACHE_DATA_BLOCK_SIZE 64
`endif

module icache_refill_responder
  import icache_refill_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int BLOCK_W    = `ICACHE_DATA_BLOCK_SIZE,
  parameter int MEM_BLOCKS = 4096,
  parameter int LATENCY    = 4,
  parameter int QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  rst_aH,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [WORD_W-1:0]     load_data,
  output logic [BLOCK_W-1:0]    dram_response,
  output logic                  dram_response_valid,
  output logic [ADDR_WIDTH-1:0] dram_response_addr,
  output logic                  busy
);

  localparam int              IDX_W  = $clog2(MEM_BLOCKS);
  // The IDLE pop cycle already counts toward the latency.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  refill_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, load_cnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr, head, resp_addr_q;
  logic [BLOCK_W-1:0]    resp_q;
  logic                  fifo_empty, fifo_full, push, pop, capture;
  logic [IDX_W-1:0]      rd_idx, ld_idx;

  logic [WORD_W-1:0]     mem_lo [MEM_BLOCKS];
  logic [WORD_W-1:0]     mem_hi [MEM_BLOCKS];

  // Address bits that never select storage.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{load_addr[ADDR_WIDTH-1:3+IDX_W], load_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  assign req_ready = !fifo_full && !flush;
  assign push      = req_valid && req_ready;

  refill_req_fifo #(
    .DEPTH (QDEPTH),
    .W     (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_aH    (rst_aH),
    .clear     (flush),
    .push      (push),
    .push_data (req_addr & ~ADDR_WIDTH'(7)),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Latency counter load value (optionally jittered)
  // ---------------------------------------------------------------------------
`ifdef ICACHE_REFILL_JITTER_EN
  logic [7:0] lfsr_q;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign load_cnt = LAT_M1 + CNT_W'(lfsr_q[1:0]);
`else
  assign load_cnt = LAT_M1;
`endif

  // ---------------------------------------------------------------------------
  // Refill engine
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_addr = addr_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && !fifo_empty) begin
          pop     = 1'b1;
          addr_d  = head;
          rd_addr = head;
          // A zero load means the pop cycle is the whole latency.
          if (load_cnt == '0) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = load_cnt;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Counter reaches 0 on this edge: sample the store now.
          if (cnt_q == CNT_W'(1)) begin
            capture = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_idx = rd_addr[3 +: IDX_W];
  assign ld_idx = load_addr[3 +: IDX_W];

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      resp_q      <= '0;
      resp_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      // Response data/address hold until the next capture.
      if (capture) begin
        resp_q      <= {mem_hi[rd_idx], mem_lo[rd_idx]};
        resp_addr_q <= rd_addr;
      end
    end
  end

  // A load landing on the capture edge is not seen by that read.
  always_ff @(posedge clk) begin
    if (load_we) begin
      if (load_addr[2]) mem_hi[ld_idx] <= load_data;
      else              mem_lo[ld_idx] <= load_data;
    end
  end

  assign dram_response       = resp_q;
  assign dram_response_valid = (state_q == RESP);
  assign dram_response_addr  = resp_addr_q;
  assign busy                = !fifo_empty || (state_q != IDLE);

endmodule
